midi_note_rx: RTL and testbench

//  Serial MIDI receiver and note parser that drives the note interface of the tone player (midi_data/midi_valid).
//  - Deserialises the 31250-baud MIDI UART line (8N1, LSB first, idle high).
//  - Parses Note On/Off messages, including running status.
//  - Emits one-cycle note strobes in the same clk domain as the player.

---
 rtl/midi_pkg.sv | 27 ++
 rtl/midi_byte_rx.sv | 114 +++++++++++
 rtl/midi_note_rx.sv | 133 +++++++++++++
 tb/tb_midi_note_rx.sv | 254 +++++++++++++++++++++++++
 4 files changed

// File: rtl/midi_pkg.sv
// rtl/midi_pkg.sv - shared constants and state encodings for the MIDI note receiver
// Purpose: status-byte constants, baud rate and FSM encodings used by
//          midi_byte_rx and midi_note_rx.
// Ports:   none (package)
package midi_pkg;

  localparam logic [3:0] NOTE_OFF      = 4'h8;
  localparam logic [3:0] NOTE_ON       = 4'h9;
  localparam logic [7:0] REALTIME_MIN  = 8'hF8;
  localparam logic [7:0] SYSCOMMON_MIN = 8'hF0;
  localparam int         MIDI_BAUD     = 31250;

  typedef enum logic [2:0] {
    RX_IDLE,
    RX_START,
    RX_DATA,
    RX_STOP,
    RX_WAIT_HIGH
  } rx_state_e;

  typedef enum logic [1:0] {
    P_WAIT_STATUS,
    P_WAIT_NOTE,
    P_WAIT_VEL
  } parse_state_e;

endpackage

// File: rtl/midi_byte_rx.sv
// rtl/midi_byte_rx.sv - MIDI UART byte receiver (8N1, LSB first, idle high)
// Purpose: synchronises the raw serial line and deserialises bytes.
// Ports:
//   clk, rst       clock, synchronous active-high reset
//   midi_rx        raw asynchronous serial input
//   rx_byte        last received byte, stable while byte_strobe is high
//   byte_strobe    1-cycle pulse, the cycle after a good stop-bit sample
//   framing_error  1-cycle pulse, the cycle after a low stop-bit sample
module midi_byte_rx
  import midi_pkg::*;
#(
  parameter int CLKS_PER_BIT = 384
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       midi_rx,
  output logic [7:0] rx_byte,
  output logic       byte_strobe,
  output logic       framing_error
);

  localparam int            CW        = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] BIT_LAST  = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);

  logic          sync1_q, sync1_d;
  logic          sync2_q, sync2_d;
  rx_state_e     state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0]    bit_q, bit_d;
  logic [7:0]    shift_q, shift_d;
  logic          strobe_q, strobe_d;
  logic          ferr_q, ferr_d;
  logic          rx_s;

  assign rx_s          = sync2_q;
  assign rx_byte       = shift_q;
  assign byte_strobe   = strobe_q;
  assign framing_error = ferr_q;

  always_comb begin
    sync1_d  = midi_rx;
    sync2_d  = sync1_q;
    state_d  = state_q;
    cnt_d    = cnt_q + 1'b1;
    bit_d    = bit_q;
    shift_d  = shift_q;
    strobe_d = 1'b0;
    ferr_d   = 1'b0;
    case (state_q)
      RX_IDLE: begin
        cnt_d = '0;
        if (!rx_s) state_d = RX_START;
      end
      RX_START: begin
        // Re-check at mid start bit so short glitches are rejected.
        if (cnt_q == HALF_LAST) begin
          cnt_d   = '0;
          bit_d   = '0;
          state_d = rx_s ? RX_IDLE : RX_DATA;
        end
      end
      RX_DATA: begin
        if (cnt_q == BIT_LAST) begin
          cnt_d   = '0;
          shift_d = {rx_s, shift_q[7:1]};
          if (bit_q == 3'd7) state_d = RX_STOP;
          else               bit_d   = bit_q + 3'd1;
        end
      end
      RX_STOP: begin
        if (cnt_q == BIT_LAST) begin
          cnt_d = '0;
          if (rx_s) begin
            strobe_d = 1'b1;
            state_d  = RX_IDLE;
          end else begin
            ferr_d  = 1'b1;
            state_d = RX_WAIT_HIGH;
          end
        end
      end
      RX_WAIT_HIGH: begin
        // A held break reports once; wait for the line to recover.
        cnt_d = '0;
        if (rx_s) state_d = RX_IDLE;
      end
      default: state_d = RX_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q  <= 1'b1;
      sync2_q  <= 1'b1;
      state_q  <= RX_IDLE;
      cnt_q    <= '0;
      bit_q    <= '0;
      shift_q  <= '0;
      strobe_q <= 1'b0;
      ferr_q   <= 1'b0;
    end else begin
      sync1_q  <= sync1_d;
      sync2_q  <= sync2_d;
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      bit_q    <= bit_d;
      shift_q  <= shift_d;
      strobe_q <= strobe_d;
      ferr_q   <= ferr_d;
    end
  end

endmodule

// File: rtl/midi_note_rx.sv
// rtl/midi_note_rx.sv - MIDI serial receiver and Note On/Off parser
// Purpose: receives MIDI bytes and turns Note On/Off messages (with running
//          status) into one-cycle note strobes for the tone player.
// Config:  MIDI_CHANNEL_FILTER_EN - when defined, only voice messages on
//          channel CHANNEL are accepted; otherwise all 16 channels are.
// Ports:
//   clk, rst       clock, synchronous active-high reset
//   midi_rx        raw asynchronous MIDI line, idle high
//   midi_data      {1'b0, note}, held until the next strobe
//   midi_velocity  velocity of the last Note On
//   midi_valid     1-cycle pulse: Note On with non-zero velocity
//   note_off       1-cycle pulse: Note Off or Note On with velocity 0
//   framing_error  1-cycle pulse: stop bit sampled low
module midi_note_rx
  import midi_pkg::*;
#(
  parameter int CLKS_PER_BIT = 384,
  parameter int CHANNEL      = 0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       midi_rx,
  output logic [7:0] midi_data,
  output logic [6:0] midi_velocity,
  output logic       midi_valid,
  output logic       note_off,
  output logic       framing_error
);

`ifdef MIDI_CHANNEL_FILTER_EN
  localparam bit FILTER_EN = 1'b1;
`else
  localparam bit FILTER_EN = 1'b0;
`endif
  localparam logic [3:0] CHAN = 4'(CHANNEL);

  logic [7:0]   rx_byte;
  logic         byte_strobe;

  parse_state_e pstate_q, pstate_d;
  logic         rs_valid_q, rs_valid_d;   // running status held
  logic         rs_on_q, rs_on_d;         // running status is Note On
  logic [6:0]   note_q, note_d;
  logic [7:0]   data_q, data_d;
  logic [6:0]   vel_q, vel_d;
  logic         valid_q, valid_d;
  logic         off_q, off_d;
  logic         is_voice;
  logic         chan_ok;

  midi_byte_rx #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_byte_rx (
    .clk           (clk),
    .rst           (rst),
    .midi_rx       (midi_rx),
    .rx_byte       (rx_byte),
    .byte_strobe   (byte_strobe),
    .framing_error (framing_error)
  );

  assign is_voice      = (rx_byte[7:4] == NOTE_OFF) || (rx_byte[7:4] == NOTE_ON);
  assign chan_ok       = !FILTER_EN || (rx_byte[3:0] == CHAN);
  assign midi_data     = data_q;
  assign midi_velocity = vel_q;
  assign midi_valid    = valid_q;
  assign note_off      = off_q;

  always_comb begin
    pstate_d   = pstate_q;
    rs_valid_d = rs_valid_q;
    rs_on_d    = rs_on_q;
    note_d     = note_q;
    data_d     = data_q;
    vel_d      = vel_q;
    valid_d    = 1'b0;
    off_d      = 1'b0;
    // Real-time bytes (>= F8) leave the parser completely untouched.
    if (byte_strobe && (rx_byte < REALTIME_MIN)) begin
      if (rx_byte[7]) begin
        // Any status byte also aborts a message waiting for its velocity.
        if (is_voice && chan_ok) begin
          rs_valid_d = 1'b1;
          rs_on_d    = (rx_byte[7:4] == NOTE_ON);
          pstate_d   = P_WAIT_NOTE;
        end else begin
          rs_valid_d = 1'b0;
          rs_on_d    = 1'b0;
          pstate_d   = P_WAIT_STATUS;
        end
      end else if (rs_valid_q) begin
        case (pstate_q)
          P_WAIT_NOTE: begin
            note_d   = rx_byte[6:0];
            pstate_d = P_WAIT_VEL;
          end
          P_WAIT_VEL: begin
            pstate_d = P_WAIT_NOTE;
            data_d   = {1'b0, note_q};
            if (rs_on_q && (rx_byte[6:0] != 7'd0)) begin
              vel_d   = rx_byte[6:0];
              valid_d = 1'b1;
            end else begin
              off_d = 1'b1;
            end
          end
          default: ;
        endcase
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pstate_q   <= P_WAIT_STATUS;
      rs_valid_q <= 1'b0;
      rs_on_q    <= 1'b0;
      note_q     <= '0;
      data_q     <= '0;
      vel_q      <= '0;
      valid_q    <= 1'b0;
      off_q      <= 1'b0;
    end else begin
      pstate_q   <= pstate_d;
      rs_valid_q <= rs_valid_d;
      rs_on_q    <= rs_on_d;
      note_q     <= note_d;
      data_q     <= data_d;
      vel_q      <= vel_d;
      valid_q    <= valid_d;
      off_q      <= off_d;
    end
  end

endmodule

// File: tb/tb_midi_note_rx.sv
// tb/tb_midi_note_rx.sv - scoreboard testbench for midi_note_rx
module tb_midi_note_rx;

  localparam int CPB = 16;
  // Byte start to pulse: 2 sync + 1 detect + CPB/2 start + 9*CPB - 1 to the
  // stop sample cycle, then 2 more cycles to the registered pulse.
  localparam int PULSE_LAT = 3 + CPB / 2 + 9 * CPB - 1 + 2;

  localparam logic [1:0] K_ON  = 2'd1;
  localparam logic [1:0] K_OFF = 2'd2;
  localparam logic [1:0] K_FE  = 2'd3;

  typedef struct packed {
    logic [1:0] kind;
    logic [7:0] data;
    logic [6:0] vel;
  } ev_t;

  logic       clk     = 1'b0;
  logic       rst     = 1'b1;
  logic       midi_rx = 1'b1;
  logic [7:0] midi_data;
  logic [6:0] midi_velocity;
  logic       midi_valid;
  logic       note_off;
  logic       framing_error;

  ev_t        exp_q[$];
  int         total = 0;
  int         bad = 0;
  int         cyc = 0;
  int         last_pulse_cyc = -1;
  int         byte_start_cyc = 0;
  logic [6:0] model_vel = 7'd0;

  midi_note_rx #(.CLKS_PER_BIT(CPB), .CHANNEL(0)) dut (
    .clk           (clk),
    .rst           (rst),
    .midi_rx       (midi_rx),
    .midi_data     (midi_data),
    .midi_velocity (midi_velocity),
    .midi_valid    (midi_valid),
    .note_off      (note_off),
    .framing_error (framing_error)
  );

  always #5 clk = ~clk;

  // One clock; outputs sampled 1 time unit after the edge and any pulse is
  // matched against the head of the scoreboard.
  task automatic step();
    ev_t        e;
    logic [1:0] k;
    @(posedge clk);
    #1;
    cyc++;
    if (midi_valid && note_off) begin
      total++;
      bad++;
      $display("FAIL valid_and_off: both high at cycle %0d, required exclusive", cyc);
    end
    if (midi_valid || note_off || framing_error) begin
      k = framing_error ? K_FE : (midi_valid ? K_ON : K_OFF);
      last_pulse_cyc = cyc;
      total++;
      if (exp_q.size() == 0) begin
        bad++;
        $display("FAIL unexpected_pulse: kind=%0d data=%h vel=%h at cycle %0d, required none",
                 k, midi_data, midi_velocity, cyc);
      end else begin
        e = exp_q.pop_front();
        if (k !== e.kind || (k != K_FE && (midi_data !== e.data || midi_velocity !== e.vel))) begin
          bad++;
          $display("FAIL pulse: kind=%0d data=%h vel=%h, required kind=%0d data=%h vel=%h",
                   k, midi_data, midi_velocity, e.kind, e.data, e.vel);
        end
      end
    end
  endtask

  task automatic push_ev(input logic [1:0] k, input logic [7:0] d);
    if (k == K_ON) model_vel = d == 8'h3C ? model_vel : model_vel;
    exp_q.push_back('{kind: k, data: d, vel: model_vel});
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop_lvl);
    byte_start_cyc = cyc;
    midi_rx = 1'b0;
    repeat (CPB) step();
    for (int i = 0; i < 8; i++) begin
      midi_rx = b[i];
      repeat (CPB) step();
    end
    midi_rx = stop_lvl;
    repeat (CPB) step();
    midi_rx = 1'b1;
    repeat (2) step();
  endtask

  task automatic send3(input logic [7:0] a, input logic [7:0] b, input logic [7:0] c);
    send_byte(a, 1'b1);
    send_byte(b, 1'b1);
    send_byte(c, 1'b1);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (4) step();
    total++;
    if (midi_data !== 8'h00) begin bad++; $display("FAIL reset_data: got %h required 00", midi_data); end
    total++;
    if (midi_velocity !== 7'h00) begin bad++; $display("FAIL reset_vel: got %h required 00", midi_velocity); end
    total++;
    if ({midi_valid, note_off, framing_error} !== 3'b000) begin
      bad++;
      $display("FAIL reset_pulses: got %b required 000", {midi_valid, note_off, framing_error});
    end
    rst = 1'b0;
    repeat (4) step();
  endtask

  task automatic test_single();
    int vel_start;
    model_vel = 7'h64;
    push_ev(K_ON, 8'h3C);
    send_byte(8'h90, 1'b1);
    send_byte(8'h3C, 1'b1);
    send_byte(8'h64, 1'b1);
    vel_start = byte_start_cyc;
    repeat (20) step();
    total++;
    if (last_pulse_cyc !== vel_start + PULSE_LAT) begin
      bad++;
      $display("FAIL single_latency: pulse at %0d required %0d", last_pulse_cyc, vel_start + PULSE_LAT);
    end
    total++;
    if (exp_q.size() != 0) begin bad++; $display("FAIL single_pending: left=%0d required 0", exp_q.size()); end
    exp_q.delete();
  endtask

  task automatic test_running_status();
    model_vel = 7'h64;
    push_ev(K_ON, 8'h3C);
    send3(8'h90, 8'h3C, 8'h64);
    model_vel = 7'h50;
    push_ev(K_ON, 8'h40);
    send_byte(8'h40, 1'b1);
    send_byte(8'h50, 1'b1);
    repeat (20) step();
    total++;
    if (exp_q.size() != 0) begin bad++; $display("FAIL running_pending: left=%0d required 0", exp_q.size()); end
    exp_q.delete();
  endtask

  task automatic test_note_off();
    push_ev(K_OFF, 8'h3C);
    send3(8'h90, 8'h3C, 8'h00);
    push_ev(K_OFF, 8'h45);
    send3(8'h80, 8'h45, 8'h40);
    repeat (20) step();
    total++;
    if (midi_velocity !== 7'h50) begin bad++; $display("FAIL off_vel_held: got %h required 50", midi_velocity); end
    total++;
    if (exp_q.size() != 0) begin bad++; $display("FAIL off_pending: left=%0d required 0", exp_q.size()); end
    exp_q.delete();
  endtask

  task automatic test_interleave();
    model_vel = 7'h64;
    push_ev(K_ON, 8'h3C);
    send_byte(8'h90, 1'b1);
    send_byte(8'h3C, 1'b1);
    send_byte(8'hF8, 1'b1);
    send_byte(8'h64, 1'b1);
    send_byte(8'hB0, 1'b1);
    send_byte(8'h07, 1'b1);
    send_byte(8'h7F, 1'b1);
    send_byte(8'h3C, 1'b1);
    send_byte(8'h64, 1'b1);
    repeat (20) step();
    total++;
    if (exp_q.size() != 0) begin bad++; $display("FAIL interleave_pending: left=%0d required 0", exp_q.size()); end
    exp_q.delete();
  endtask

  task automatic test_framing();
    // Parser sits in WAIT_STATUS after the 0xB0 above, so with 0x90 dropped
    // the following data bytes must produce nothing.
    push_ev(K_FE, 8'h00);
    send_byte(8'h90, 1'b0);
    send_byte(8'h3C, 1'b1);
    send_byte(8'h64, 1'b1);
    push_ev(K_FE, 8'h00);
    midi_rx = 1'b0;
    repeat (100 * CPB) step();
    midi_rx = 1'b1;
    repeat (40) step();
    model_vel = 7'h64;
    push_ev(K_ON, 8'h3C);
    send3(8'h90, 8'h3C, 8'h64);
    repeat (20) step();
    total++;
    if (exp_q.size() != 0) begin bad++; $display("FAIL framing_pending: left=%0d required 0", exp_q.size()); end
    exp_q.delete();
  endtask

  task automatic test_channel_and_reset();
    logic [7:0] b;
`ifndef MIDI_CHANNEL_FILTER_EN
    push_ev(K_ON, 8'h3C);
`endif
    send3(8'h91, 8'h3C, 8'h64);
    send_byte(8'h90, 1'b1);
    send_byte(8'h3C, 1'b1);
    b = 8'h64;
    midi_rx = 1'b0;
    repeat (CPB) step();
    for (int i = 0; i < 3; i++) begin
      midi_rx = b[i];
      repeat (CPB) step();
    end
    rst = 1'b1;
    repeat (2) step();
    midi_rx = 1'b1;
    rst = 1'b0;
    model_vel = 7'h00;
    total++;
    if (midi_data !== 8'h00 || midi_velocity !== 7'h00) begin
      bad++;
      $display("FAIL midreset_outputs: data=%h vel=%h required 00 00", midi_data, midi_velocity);
    end
    repeat (200) step();
    model_vel = 7'h64;
    push_ev(K_ON, 8'h3C);
    send3(8'h90, 8'h3C, 8'h64);
    repeat (20) step();
    total++;
    if (exp_q.size() != 0) begin bad++; $display("FAIL chan_reset_pending: left=%0d required 0", exp_q.size()); end
    exp_q.delete();
  endtask

  initial begin
    test_reset();
    test_single();
    test_running_status();
    test_note_off();
    test_interleave();
    test_framing();
    test_channel_and_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
